// File: rtl/rgb_button_pwm.sv
// rgb_button_pwm: N-channel button-to-LED controller.
// Each active-low button is synchronised, debounced and turned into a
// one-clock press pulse; each press updates that channel's brightness level
// (toggle or step mode), which drives a PWM LED output.
//
// Ports:
//   clk         design clock
//   reset       asynchronous active-high reset
//   button_n_i  raw active-low buttons, asynchronous to clk
//   mode_i      0 = toggle, 1 = step; used only on press events
//   led_o       PWM LED drive per channel, active-high
//   pressed_o   debounced button state per channel, active-high
//   press_o     one-clock pulse per accepted press
//   level_o     brightness levels, ch i at [i*PWM_BITS +: PWM_BITS]
module rgb_button_pwm #(
  parameter int unsigned NUM_CH          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 120_000,
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned STEP            = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            button_n_i,
  input  logic                         mode_i,
  output logic [NUM_CH-1:0]            led_o,
  output logic [NUM_CH-1:0]            pressed_o,
  output logic [NUM_CH-1:0]            press_o,
  output logic [NUM_CH*PWM_BITS-1:0]   level_o
);

  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LVL_MAX_I = (1 << PWM_BITS) - 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = PWM_BITS'(LVL_MAX_I);
  localparam logic [PWM_BITS-1:0] STEP_LIM = PWM_BITS'(LVL_MAX_I - STEP);
  localparam logic [PWM_BITS-1:0] STEP_INC = PWM_BITS'(STEP);

  logic [NUM_CH-1:0]   sync0;
  logic [NUM_CH-1:0]   sync1;
  logic [PWM_BITS-1:0] pwm_cnt;

  // Two-flop synchroniser; idle (released) level is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= '1;
      sync1 <= '1;
    end else begin
      sync0 <= button_n_i;
      sync1 <= sync0;
    end
  end

  // Free-running PWM counter shared by all channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0]    deb_cnt;
    logic                pressed_q;
    logic                press_q;
    logic                led_q;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] active;
    logic                btn_now;
    logic                differ;
    logic                accept;

    assign btn_now = ~sync1[g];
    assign differ  = (btn_now != pressed_q);
    // Input has differed for DEBOUNCE_CYCLES consecutive clocks.
    assign accept  = differ && (deb_cnt == CNT_LAST);

    // Debounce counter and state; pulse only on the press edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        deb_cnt   <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
      end else begin
        press_q <= accept && btn_now;
        if (accept) begin
          pressed_q <= btn_now;
          deb_cnt   <= '0;
        end else if (differ) begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end else begin
          deb_cnt <= '0;
        end
      end
    end

    // Level update in the clock after the press pulse; step wraps to 0.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        level <= '0;
      end else if (press_q) begin
        if (!mode_i) begin
          level <= (level == '0) ? LVL_MAX : '0;
        end else if (level > STEP_LIM) begin
          level <= '0;
        end else begin
          level <= level + STEP_INC;
        end
      end
    end

    // Shadow level loads only at the end of a period to avoid glitches.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        active <= '0;
        led_q  <= 1'b0;
      end else begin
        if (pwm_cnt == LVL_MAX) begin
          active <= level;
        end
        led_q <= (active > pwm_cnt);
      end
    end

    assign pressed_o[g]                        = pressed_q;
    assign press_o[g]                          = press_q;
    assign led_o[g]                            = led_q;
    assign level_o[g*PWM_BITS +: PWM_BITS]     = level;
  end

endmodule

// File: tb/tb_rgb_button_pwm.sv
// Testbench for rgb_button_pwm with NUM_CH=3, DEBOUNCE_CYCLES=4,
// PWM_BITS=4, STEP=4. Press events are scoreboarded: expected
// {cycle, press mask, levels one clock later} are queued at stimulus time
// and matched against what the negedge monitor records.
module tb_rgb_button_pwm;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  press;
    logic [11:0] lvl;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [2:0]  btn_n;
  logic        mode;
  logic [2:0]  led_o;
  logic [2:0]  pressed_o;
  logic [2:0]  press_o;
  logic [11:0] level_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cyc = 0;
  logic [3:0]  m_cnt;
  logic [3:0]  mdl [3];
  ev_t         exp_q [$];
  ev_t         obs_q [$];

  logic        pend = 1'b0;
  logic [31:0] pend_cyc = 0;
  logic [2:0]  pend_mask = 3'b000;

  rgb_button_pwm #(
    .NUM_CH(3), .DEBOUNCE_CYCLES(4), .PWM_BITS(4), .STEP(4)
  ) dut (
    .clk(clk), .reset(rst), .button_n_i(btn_n), .mode_i(mode),
    .led_o(led_o), .pressed_o(pressed_o), .press_o(press_o), .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Reference PWM phase: 0 on reset, +1 every clock.
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 4'd0;
    else     m_cnt <= m_cnt + 4'd1;
  end

  // Monitor: record each press pulse with the levels seen one clock later.
  always @(negedge clk) begin
    if (pend) obs_q.push_back({pend_cyc, pend_mask, level_o});
    pend      <= (press_o != 3'b000);
    pend_cyc  <= cyc;
    pend_mask <= press_o;
  end

  function automatic logic [3:0] next_lvl(input logic [3:0] l, input logic m);
    if (!m) return (l == 4'd0) ? 4'd15 : 4'd0;
    if (l > 4'd11) return 4'd0;
    return l + 4'd4;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst   = 1'b1;
    btn_n = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mdl[i] = 4'd0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_press(input logic [2:0] mask);
    ev_t e;
    @(posedge clk); #1;
    btn_n = btn_n & ~mask;
    for (int i = 0; i < 3; i++) if (mask[i]) mdl[i] = next_lvl(mdl[i], mode);
    e.cyc   = 32'(cyc + 32'd6);
    e.press = mask;
    e.lvl   = {mdl[2], mdl[1], mdl[0]};
    exp_q.push_back(e);
    repeat (8) @(posedge clk);
    #1;
    btn_n = btn_n | mask;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset();
    ev_t e;
    ev_t o;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (led_o !== 3'b000)     begin n_bad++; $display("FAIL reset_led: got %b want 000", led_o); end
    n_cmp++; if (pressed_o !== 3'b000) begin n_bad++; $display("FAIL reset_pressed: got %b want 000", pressed_o); end
    n_cmp++; if (press_o !== 3'b000)   begin n_bad++; $display("FAIL reset_press: got %b want 000", press_o); end
    n_cmp++; if (level_o !== 12'h000)  begin n_bad++; $display("FAIL reset_level: got %h want 000", level_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    // Ch2 pressed and held so state is non-zero when reset hits.
    repeat (3) @(posedge clk);
    #1;
    btn_n[2] = 1'b0;
    mdl[2]   = next_lvl(mdl[2], mode);
    e.cyc = 32'(cyc + 32'd6); e.press = 3'b100; e.lvl = {mdl[2], mdl[1], mdl[0]};
    exp_q.push_back(e);
    repeat (30) @(posedge clk);
    #1;
    btn_n[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pressed_o !== 3'b100) begin n_bad++; $display("FAIL pre_reset_pressed: got %b want 100", pressed_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (led_o !== 3'b000)     begin n_bad++; $display("FAIL midreset_led: got %b want 000", led_o); end
    n_cmp++; if (pressed_o !== 3'b000) begin n_bad++; $display("FAIL midreset_pressed: got %b want 000", pressed_o); end
    n_cmp++; if (press_o !== 3'b000)   begin n_bad++; $display("FAIL midreset_press: got %b want 000", press_o); end
    n_cmp++; if (level_o !== 12'h000)  begin n_bad++; $display("FAIL midreset_level: got %h want 000", level_o); end
    for (int i = 0; i < 3; i++) mdl[i] = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    btn_n[2] = 1'b1;
    rst      = 1'b0;
    // Ch0 still low: needs a fresh 2+4 clocks after reset release.
    mdl[0] = next_lvl(mdl[0], mode);
    e.cyc = 32'(cyc + 32'd6); e.press = 3'b001; e.lvl = {mdl[2], mdl[1], mdl[0]};
    exp_q.push_back(e);
    repeat (12) @(posedge clk);
    #1;
    btn_n[0] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (pressed_o !== 3'b000) begin n_bad++; $display("FAIL reset_release: got %b want 000", pressed_o); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL reset_sb: no press seen, want cyc=%0d press=%b", e.cyc, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL reset_sb: got cyc=%0d press=%b lvl=%h, want cyc=%0d press=%b lvl=%h",
                   o.cyc, o.press, o.lvl, e.cyc, e.press, e.lvl);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL reset_extra: unexpected press=%b at cyc=%0d", obs_q[0].press, obs_q[0].cyc);
      obs_q.delete();
    end
    apply_reset();
  endtask

  task automatic test_debounce();
    ev_t e;
    ev_t o;
    mode = 1'b1;
    @(posedge clk); #1;
    btn_n[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    btn_n[1] = 1'b1;
    @(posedge clk); #1;
    btn_n[1] = 1'b0;
    mdl[1] = next_lvl(mdl[1], mode);
    e.cyc = 32'(cyc + 32'd6); e.press = 3'b010; e.lvl = {mdl[2], mdl[1], mdl[0]};
    exp_q.push_back(e);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (pressed_o[1] !== 1'b1) begin n_bad++; $display("FAIL bounce_pressed: got %b want 1", pressed_o[1]); end
    @(posedge clk); #1;
    btn_n[1] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (pressed_o[1] !== 1'b0) begin n_bad++; $display("FAIL bounce_release: got %b want 0", pressed_o[1]); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL bounce_sb: no press seen, want cyc=%0d press=%b", e.cyc, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL bounce_sb: got cyc=%0d press=%b lvl=%h, want cyc=%0d press=%b lvl=%h",
                   o.cyc, o.press, o.lvl, e.cyc, e.press, e.lvl);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL bounce_extra: unexpected press=%b at cyc=%0d", obs_q[0].press, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_pwm();
    ev_t e;
    ev_t o;
    int  win_exp [7] = '{4, 4, 4, 4, 4, 8, 8};
    int  highs;
    int  w;
    mode = 1'b1;
    repeat (20) @(posedge clk);
    // Align to a period boundary using the reference phase.
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_cnt == 4'd0) break;
    end
    highs = 0;
    w     = 0;
    for (int k = 0; k < 112; k++) begin
      @(posedge clk); #1;
      // Level update lands at counter 5 of window 4: mid-period.
      if (k == 61) begin
        btn_n[1] = 1'b0;
        mdl[1]   = next_lvl(mdl[1], mode);
        e.cyc = 32'(cyc + 32'd6); e.press = 3'b010; e.lvl = {mdl[2], mdl[1], mdl[0]};
        exp_q.push_back(e);
      end
      if (k == 71) btn_n[1] = 1'b1;
      @(negedge clk);
      if (led_o[1]) highs++;
      if (m_cnt == 4'd0) begin
        n_cmp++;
        if (highs != win_exp[w]) begin
          n_bad++; $display("FAIL pwm_window%0d: got %0d lit clocks want %0d", w, highs, win_exp[w]);
        end
        highs = 0;
        w++;
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL pwm_sb: no press seen, want cyc=%0d press=%b", e.cyc, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL pwm_sb: got cyc=%0d press=%b lvl=%h, want cyc=%0d press=%b lvl=%h",
                   o.cyc, o.press, o.lvl, e.cyc, e.press, e.lvl);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL pwm_extra: unexpected press=%b at cyc=%0d", obs_q[0].press, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_toggle();
    ev_t e;
    ev_t o;
    mode = 1'b0;
    do_press(3'b001);
    do_press(3'b001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL toggle_sb: no press seen, want cyc=%0d press=%b", e.cyc, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL toggle_sb: got cyc=%0d press=%b lvl=%h, want cyc=%0d press=%b lvl=%h",
                   o.cyc, o.press, o.lvl, e.cyc, e.press, e.lvl);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL toggle_extra: unexpected press=%b at cyc=%0d", obs_q[0].press, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_step_wrap();
    ev_t e;
    ev_t o;
    mode = 1'b1;
    for (int n = 0; n < 5; n++) do_press(3'b100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL step_sb: no press seen, want cyc=%0d press=%b", e.cyc, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL step_sb: got cyc=%0d press=%b lvl=%h, want cyc=%0d press=%b lvl=%h",
                   o.cyc, o.press, o.lvl, e.cyc, e.press, e.lvl);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL step_extra: unexpected press=%b at cyc=%0d", obs_q[0].press, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    ev_t e;
    ev_t o;
    apply_reset();
    mode = 1'b1;
    do_press(3'b111);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL simul_sb: no press seen, want cyc=%0d press=%b", e.cyc, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL simul_sb: got cyc=%0d press=%b lvl=%h, want cyc=%0d press=%b lvl=%h",
                   o.cyc, o.press, o.lvl, e.cyc, e.press, e.lvl);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL simul_extra: unexpected press=%b at cyc=%0d", obs_q[0].press, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  initial begin
    rst   = 1'b1;
    btn_n = 3'b111;
    mode  = 1'b0;
    for (int i = 0; i < 3; i++) mdl[i] = 4'd0;
    test_reset();
    test_debounce();
    test_pwm();
    test_toggle();
    test_step_wrap();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_button_pwm.md
Name: rgb_button_pwm

Overview:
- Parametrised N-channel button-to-LED controller; successor to the fixed 3-button/3-LED on/off path between the board top and the main logic.
- Per channel: synchronises and debounces an active-low button, emits a press pulse, and updates a brightness level (toggle or step mode).
- Drives a PWM LED output per channel; outputs feed the SB_RGBA_DRV PWM inputs (ch0=red, ch1=green, ch2=blue by default).

Parameters:
- NUM_CH, 3, number of button/LED channels (≥1).
- DEBOUNCE_CYCLES, 120_000, clocks an input must be stable before acceptance (10 ms @ 12 MHz); ≥2.
- PWM_BITS, 8, PWM counter and level width.
- STEP, 32, level increment in step mode; 1 ≤ STEP ≤ 2^PWM_BITS-1.

Ports:
- clk  input  1  design clock (12 MHz).
- reset  input  1  asynchronous, active-high reset.
- button_n_i  input  NUM_CH  raw active-low buttons (0 = pressed), asynchronous to clk.
- mode_i  input  1  0 = toggle mode, 1 = step mode; sampled only on press events.
- led_o  output  NUM_CH  PWM LED drive, active-high (1 = lit).
- pressed_o  output  NUM_CH  debounced button state, active-high.
- press_o  output  NUM_CH  one-cycle pulse per accepted press.
- level_o  output  NUM_CH*PWM_BITS  current brightness level; ch i at bits [i*PWM_BITS +: PWM_BITS].

Behaviour:
- Reset is asynchronous, active-high, and clears everything:
  - sync flops = 1; debounced state = released.
  - debounce counters = 0; PWM counter = 0; levels = 0; active levels = 0.
  - led_o = 0, pressed_o = 0, press_o = 0, level_o = 0.
  - Reset mid-debounce or mid-PWM discards all progress; no press pulse results.
- Synchroniser: 2 flip-flops per channel.
- Debounce (per channel, independent):
  - When the synced value equals the debounced state, the counter is held at 0.
  - When it differs, the counter increments each clock.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the value still differs, the debounced state takes the synced value and the counter clears.
  - Any bounce back to equality before that point clears the counter.
  - Latency from a stable pin change to pressed_o change: 2 + DEBOUNCE_CYCLES clocks.
- press_o[i] is registered and high for exactly one clock, in the same clock pressed_o[i] first goes 1. The release edge produces no pulse.
- Level update: in the clock after press_o[i], level[i] updates from mode_i as sampled with press_o[i].
  - Toggle mode: level = (level == 0) ? 2^PWM_BITS-1 : 0.
  - Step mode: level = level + STEP; if level > 2^PWM_BITS-1-STEP, it wraps to exactly 0 (no modular remainder).
  - Simultaneous presses on several channels update each channel independently in the same clock.
- PWM:
  - Single free-running PWM_BITS counter shared by all channels; counts 0 .. 2^PWM_BITS-1, then wraps to 0.
  - A shadow "active level" per channel loads level[i] only in the clock where the counter equals 2^PWM_BITS-1, so a new level takes effect at the next period start with no mid-period glitch.
  - led_o[i] registered = (active_level[i] > pwm_cnt); duty = level / 2^PWM_BITS.
  - level 0 = never lit; max level = lit all but one clock per period.
- level_o reflects level immediately after update, not the shadow value.
- No state machine beyond per-channel debounce and level; channels share only the PWM counter and mode_i.

Test Plan (bench params NUM_CH=3, DEBOUNCE_CYCLES=4, PWM_BITS=4, STEP=4):
- Reset check: assert reset mid-run with ch0 held low 3 clocks. Required: all outputs 0 immediately; no press_o after deassert until a fresh stable low of 2+4 clocks.
- Debounce/bounce: ch1 low 3 clocks, high 1, low 10. Required: press_o[1] exactly once, 6 clocks after the final low edge; pressed_o[1]=1 from then on; no pulse on release.
- Toggle mode (mode_i=0): two presses on ch0. Required: level_o[3:0] goes 0→15 the clock after the first press_o, then 15→0 after the second.
- Step wrap (mode_i=1): five presses on ch2. Required: level_o[11:8] = 4, 8, 12, 0, 4.
- PWM duty: ch1 level=4, observe 3 periods. Required: led_o[1] high 4 of every 16 clocks. Changing the level mid-period leaves the current period unaltered; the new duty starts at the next counter wrap.
- Simultaneous: all three buttons pressed on the same clock in step mode. Required: press_o=3'b111 in one clock; all levels = 4 the next clock.
